// File: rtl/dma_pkg.sv
// Shared types for the single-channel DMA engine.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    MODE_COPY = 1'b0,
    MODE_FILL = 1'b1
  } mode_t;

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter: counts 0..rollover_val, wraps to 0, synchronous clear.
// rollover_flag is combinational so the owner sees "last" in the same cycle.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

  // NOTE: state updates use <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      count_out <= (count_out == rollover_val) ? '0 : count_out + ONE;
    end
  end

  assign rollover_flag = (count_out == rollover_val);

endmodule

// File: rtl/dma_engine.sv
// Single-channel DMA engine: COPY or FILL of xfer_len elements over a ready-handshaked port.
// Define DMA_OVERLAP_EN for memmove semantics (descending copy when dst overlaps above src).
module dma_engine
  import dma_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  input  mode_t             mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  xfer_len,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  xfer_cnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t            state, state_nxt;
  mode_t             mode_r;
  logic [ADDR_W-1:0] src_r, dst_r;
  logic [LEN_W-1:0]  len_r, cnt_r;
  logic [DATA_W-1:0] fill_r, data_r;
  logic              aborted_r, desc_r, desc_start;

  logic              rst_n;
  logic              accept, rd_fire, wr_fire;
  logic [LEN_W-1:0]  idx, len_m1, off;
  logic [ADDR_W-1:0] addr_off, rd_addr, wr_addr;
  logic              last;

  assign rst_n   = ~RST;
  assign accept  = (state == IDLE) && start;
  assign rd_fire = (state == READ)  && mem_ready && !abort;
  assign wr_fire = (state == WRITE) && mem_ready && !abort;
  assign len_m1  = len_r - ONE;

  // Element index; "last" is decided against len-1 while idx is still current.
  flex_counter #(
    .NUM_CNT_BITS(LEN_W)
  ) u_idx (
    .CLK          (CLK),
    .nRST         (rst_n),
    .clear        (accept),
    .count_enable (wr_fire && !last),
    .rollover_val (len_m1),
    .count_out    (idx),
    .rollover_flag(last)
  );

`ifdef DMA_OVERLAP_EN
  localparam int EXT_W = ADDR_W + 1;
  logic [EXT_W-1:0] src_ext, dst_ext, src_end;
  assign src_ext    = {1'b0, src_addr};
  assign dst_ext    = {1'b0, dst_addr};
  assign src_end    = src_ext + EXT_W'(xfer_len);
  assign desc_start = (mode == MODE_COPY) && (dst_ext > src_ext) && (dst_ext < src_end);
`else
  assign desc_start = 1'b0;
`endif

  // Offsets wrap modulo 2^ADDR_W by truncation; no error on wrap.
  assign off      = desc_r ? (len_m1 - idx) : idx;
  assign addr_off = ADDR_W'(off);
  assign rd_addr  = src_r + addr_off;
  assign wr_addr  = dst_r + addr_off;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Transfer configuration is captured only on an accepted start.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_r <= MODE_COPY;
      src_r  <= '0;
      dst_r  <= '0;
      len_r  <= '0;
      fill_r <= '0;
      desc_r <= 1'b0;
    end else if (accept) begin
      mode_r <= mode;
      src_r  <= src_addr;
      dst_r  <= dst_addr;
      len_r  <= xfer_len;
      fill_r <= fill_data;
      desc_r <= desc_start;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r     <= '0;
      aborted_r <= 1'b0;
    end else if (accept) begin
      cnt_r     <= '0;
      aborted_r <= 1'b0;
    end else begin
      if (wr_fire) cnt_r <= cnt_r + ONE;
      if (busy && abort) aborted_r <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_r <= '0;
    end else if (rd_fire) begin
      data_r <= mem_rdata;
    end
  end

  // Strobes are gated by abort so an aborted request never commits.
  // NOTE: every output of this block gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (xfer_len == '0)         state_nxt = DONE;
          else if (mode == MODE_FILL) state_nxt = WRITE;
          else                        state_nxt = READ;
        end
      end
      READ: begin
        mem_ren  = !abort;
        mem_addr = rd_addr;
        if (abort)          state_nxt = DONE;
        else if (mem_ready) state_nxt = WRITE;
      end
      WRITE: begin
        mem_wen   = !abort;
        mem_addr  = wr_addr;
        mem_wdata = (mode_r == MODE_FILL) ? fill_r : data_r;
        if (abort) begin
          state_nxt = DONE;
        end else if (mem_ready) begin
          if (last)                     state_nxt = DONE;
          else if (mode_r == MODE_FILL) state_nxt = WRITE;
          else                          state_nxt = READ;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state == READ) || (state == WRITE);
  assign done     = (state == DONE);
  assign aborted  = aborted_r;
  assign xfer_cnt = cnt_r;

endmodule

// File: tb/tb_dma_engine.sv
// Directed self-checking bench for dma_engine with a 256-entry memory model and optional wait states.
module tb_dma_engine;
  import dma_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start, abort;
  mode_t      mode;
  logic [7:0] src_addr, dst_addr, xfer_len, fill_data;
  logic       busy, done, aborted;
  logic [7:0] xfer_cnt, mem_addr, mem_wdata, mem_rdata;
  logic       mem_ren, mem_wen, mem_ready;

  dma_engine #(.ADDR_W(8), .DATA_W(8), .LEN_W(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .abort    (abort),
    .mode     (mode),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .xfer_len (xfer_len),
    .fill_data(fill_data),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .xfer_cnt (xfer_cnt),
    .mem_addr (mem_addr),
    .mem_ren  (mem_ren),
    .mem_wen  (mem_wen),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: single writer process; bench preloads through the poke port.
  logic [7:0] mem [256];
  logic       poke_en = 1'b0;
  logic [7:0] poke_addr = '0, poke_data = '0;
  logic       stall_en = 1'b0;
  int         wait_cnt = 0;
  int         wr_total = 0;
  int         strobe_total = 0;

  assign mem_rdata = mem[mem_addr];
  assign mem_ready = !stall_en || (wait_cnt == 3);

  always @(posedge CLK) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    if (mem_wen && mem_ready) begin
      mem[mem_addr] <= mem_wdata;
      wr_total      <= wr_total + 1;
    end
    if (mem_ren || mem_wen) strobe_total <= strobe_total + 1;
    if ((mem_ren || mem_wen) && !mem_ready) wait_cnt <= wait_cnt + 1;
    else                                    wait_cnt <= 0;
  end

  // Stall monitor: request signals must hold while mem_ready is low.
  logic       mon_en = 1'b0;
  logic       have_prev = 1'b0;
  logic [7:0] s_addr, s_wdata;
  logic       s_ren, s_wen;

  always @(negedge CLK) begin
    if (mon_en && have_prev) begin
      check("stall_addr",  32'(mem_addr),  32'(s_addr));
      check("stall_wdata", 32'(mem_wdata), 32'(s_wdata));
      check("stall_ren",   32'(mem_ren),   32'(s_ren));
      check("stall_wen",   32'(mem_wen),   32'(s_wen));
    end
    have_prev = mon_en && (mem_ren || mem_wen) && !mem_ready;
    s_addr  = mem_addr;
    s_wdata = mem_wdata;
    s_ren   = mem_ren;
    s_wen   = mem_wen;
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    @(posedge CLK);
    #1 poke_en = 1'b0;
  endtask

  // Pulses start for one edge, scrambles the inputs, then counts edges until done (start edge = 1).
  task automatic run(input mode_t m, input logic [7:0] s, input logic [7:0] d,
                     input logic [7:0] len, input logic [7:0] fill,
                     input int budget, output int cyc);
    @(negedge CLK);
    mode = m; src_addr = s; dst_addr = d; xfer_len = len; fill_data = fill;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    src_addr = ~s; dst_addr = ~d; xfer_len = len + 8'd3; fill_data = ~fill;
    cyc = 1;
    while (!done && cyc < budget) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
  endtask

  int cyc, w0, s0, guard;
  logic [7:0] exp_ov [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1; start = 1'b0; abort = 1'b0; mode = MODE_COPY;
    src_addr = '0; dst_addr = '0; xfer_len = '0; fill_data = '0;
    #12;
    check("rst_busy",    32'(busy),      0);
    check("rst_done",    32'(done),      0);
    check("rst_aborted", 32'(aborted),   0);
    check("rst_ren",     32'(mem_ren),   0);
    check("rst_wen",     32'(mem_wen),   0);
    check("rst_cnt",     32'(xfer_cnt),  0);
    check("rst_addr",    32'(mem_addr),  0);
    check("rst_wdata",   32'(mem_wdata), 0);
    @(negedge CLK);
    RST = 1'b0;

    // COPY, no wait states
    for (int i = 0; i < 4; i++) poke(8'(8'h10 + i), 8'(8'hA1 + i));
    w0 = wr_total;
    run(MODE_COPY, 8'h10, 8'h40, 8'd4, 8'h00, 40, cyc);
    check("copy_cycles", cyc, 9);
    check("copy_done",   32'(done), 1);
    check("copy_cnt",    32'(xfer_cnt), 4);
    @(posedge CLK); #1;
    check("copy_done_1cyc", 32'(done), 0);
    check("copy_busy_off",  32'(busy), 0);
    check("copy_writes",    wr_total - w0, 4);
    for (int i = 0; i < 4; i++) check("copy_data", 32'(mem[8'(8'h40 + i)]), 32'(8'hA1 + i));

    // COPY with 3 wait states per request
    poke(8'h20, 8'h5C); poke(8'h21, 8'hC5); poke(8'h60, 8'h00); poke(8'h61, 8'h00);
    stall_en = 1'b1; mon_en = 1'b1;
    w0 = wr_total;
    run(MODE_COPY, 8'h20, 8'h60, 8'd2, 8'h00, 60, cyc);
    check("stall_cycles", cyc, 17);
    check("stall_cnt",    32'(xfer_cnt), 2);
    @(posedge CLK); #1;
    mon_en = 1'b0; stall_en = 1'b0;
    check("stall_writes", wr_total - w0, 2);
    check("stall_d0", 32'(mem[8'h60]), 32'h5C);
    check("stall_d1", 32'(mem[8'h61]), 32'hC5);

    // FILL across the address wrap
    poke(8'hEF, 8'h00);
    run(MODE_FILL, 8'h00, 8'hF0, 8'h20, 8'h5A, 80, cyc);
    check("fill_cycles", cyc, 33);
    check("fill_cnt",    32'(xfer_cnt), 32'h20);
    @(posedge CLK); #1;
    check("fill_f0",     32'(mem[8'hF0]), 32'h5A);
    check("fill_ff",     32'(mem[8'hFF]), 32'h5A);
    check("fill_00",     32'(mem[8'h00]), 32'h5A);
    check("fill_0f",     32'(mem[8'h0F]), 32'h5A);
    check("fill_below",  32'(mem[8'hEF]), 32'h00);
    check("fill_above",  32'(mem[8'h10]), 32'hA1);

    // Zero-length transfer
    s0 = strobe_total;
    run(MODE_COPY, 8'h10, 8'h40, 8'd0, 8'h00, 10, cyc);
    check("len0_cycles",  cyc, 1);
    check("len0_done",    32'(done), 1);
    check("len0_cnt",     32'(xfer_cnt), 0);
    @(posedge CLK); #1;
    check("len0_strobes", strobe_total - s0, 0);

    // Abort during the third WRITE of an 8-element copy
    for (int i = 0; i < 8; i++) begin
      poke(8'(8'h80 + i), 8'(8'h30 + i));
      poke(8'(8'hA0 + i), 8'h00);
    end
    w0 = wr_total;
    @(negedge CLK);
    mode = MODE_COPY; src_addr = 8'h80; dst_addr = 8'hA0; xfer_len = 8'd8; start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    guard = 0;
    @(negedge CLK);
    while (!(mem_wen && (wr_total - w0 == 2)) && guard < 40) begin
      @(negedge CLK);
      guard++;
    end
    check("abort_reach_w3", 32'(guard < 40), 1);
    abort = 1'b1;
    #1;
    check("abort_wen_drop", 32'(mem_wen), 0);
    @(posedge CLK); #1;
    abort = 1'b0;
    check("abort_done",    32'(done), 1);
    check("abort_sticky",  32'(aborted), 1);
    check("abort_cnt",     32'(xfer_cnt), 2);
    check("abort_busy",    32'(busy), 0);
    @(posedge CLK); #1;
    check("abort_writes",  wr_total - w0, 2);
    check("abort_a1",      32'(mem[8'hA1]), 32'h31);
    check("abort_a2",      32'(mem[8'hA2]), 32'h00);
    check("abort_hold",    32'(aborted), 1);
    run(MODE_COPY, 8'h80, 8'hB0, 8'd1, 8'h00, 20, cyc);
    check("abort_cleared", 32'(aborted), 0);
    check("len1_cycles",   cyc, 3);

    // Overlapping copy: dst inside [src, src+len)
    for (int i = 0; i < 6; i++) poke(8'(i), (i < 4) ? 8'(i + 1) : 8'h00);
`ifdef DMA_OVERLAP_EN
    exp_ov = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd3, 8'd4};
`else
    exp_ov = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2};
`endif
    run(MODE_COPY, 8'h00, 8'h02, 8'd4, 8'h00, 40, cyc);
    check("ovl_cycles", cyc, 9);
    @(posedge CLK); #1;
    for (int i = 0; i < 6; i++) check("ovl_data", 32'(mem[i]), 32'(exp_ov[i]));

    // Asynchronous reset in the middle of a transfer
    @(negedge CLK);
    mode = MODE_COPY; src_addr = 8'h80; dst_addr = 8'hC0; xfer_len = 8'd8; start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("mid_busy",   32'(busy), 1);
    check("mid_cnt",    32'(xfer_cnt), 1);
    #1 RST = 1'b1;
    #1;
    check("arst_busy",  32'(busy), 0);
    check("arst_ren",   32'(mem_ren), 0);
    check("arst_wen",   32'(mem_wen), 0);
    check("arst_addr",  32'(mem_addr), 0);
    check("arst_wdata", 32'(mem_wdata), 0);
    check("arst_cnt",   32'(xfer_cnt), 0);
    check("arst_done",  32'(done), 0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    check("post_rst_idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
